serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
- Upstream stage of the serial divisibility checkers. Accepts parallel words over a valid/ready handshake and serialises them one bit per clock onto a single-bit stream `x` that drives the checker's `x` input.
- Emits frame markers: `sof` clears/arms the downstream checker, `eof` marks the bit at which the checker's `y` is meaningful.
- A one-word holding register lets consecutive words stream with no idle cycle between them.

Parameters:
- WIDTH, 16: bits per word; legal range is WIDTH >= 1.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to serialise
- in_valid  input  1  in_data is valid
- in_ready  output  1  feeder can take a word this cycle
- x  output  1  serial data bit
- x_valid  output  1  x carries a live bit
- sof  output  1  first bit of a word is on x
- eof  output  1  last bit of a word is on x
- busy  output  1  shifter active or holding register full

Behaviour:
- Clocking and reset
  - One clock (clk). Reset is synchronous and active-high (rst).
  - While rst is high at an edge: shifter, holding register, bit counter and state are cleared.
  - After reset: x=0, x_valid=0, sof=0, eof=0, busy=0, in_ready=1.
  - in_ready is forced to 0 in any cycle where rst=1. No accept occurs that cycle.
- Handshake
  - A word is accepted at an edge where in_valid && in_ready.
  - in_ready = !hold_full && !rst (combinational from registered state only; no path from in_valid).
  - in_data must be held stable while in_valid && !in_ready. The bench asserts this.
- State machine: IDLE and SHIFT, with a bit counter of $clog2(WIDTH+1) bits.
  - IDLE, accept at edge k: the word loads into the shifter and the state becomes SHIFT. During cycle k..k+1, x = first bit, x_valid=1, sof=1. Latency is one edge.
  - SHIFT: one bit per edge. eof=1 on the WIDTH-th bit; sof=0 except on the first bit.
  - SHIFT, accept while not on the last bit: the word goes to the holding register (hold_full=1, in_ready=0).
  - Edge that ends the last bit, three cases:
    - hold_full: the holding word moves into the shifter, hold_full=0 and sof=1 next cycle. No bubble; in_ready returns to 1 the following cycle.
    - hold empty and accept at the same edge: the new word loads straight into the shifter. No bubble.
    - otherwise: go to IDLE with x_valid=0 and x=0.
- x_valid, sof and eof are all 0 in IDLE.
- WIDTH=1: sof and eof are both high on every bit.
- busy = (state==SHIFT) || hold_full.
- Reset mid-word: both the in-flight word and the held word are discarded. There is no partial eof. The next accepted word starts cleanly with sof.
- No x_valid gaps inside a word, and none between words when the next word was available in time.

Test Plan:
1. WIDTH=16, MSB_FIRST=1, single word 16'h9D99 accepted at edge k.
   -> x = 1,0,0,1,1,1,0,1,1,0,0,1,1,0,0,1 on 16 consecutive cycles; sof on cycle 1 only; eof on cycle 16 only; x_valid drops at edge k+16; in_ready stays 1.
2. 16'h9D99 then 16'h0005, in_valid held continuously.
   -> Second word accepted at edge k+1 and in_ready=0 from k+1 to k+16; 32 contiguous x_valid cycles; second sof on cycle 17; last 16 bits are 0000000000000101; eof on cycles 16 and 32.
3. Three words 16'hFFFF, 16'h0000, 16'hAAAA presented back-to-back.
   -> Third word stalls with in_valid high and in_data stable; it is accepted one edge after the second word starts shifting; 48 contiguous bits; exactly three sof and three eof pulses.
4. rst pulsed for one cycle during bit 7 of 16'h9D99 while 16'h1234 is held.
   -> Next cycle x_valid=0, busy=0, in_ready=1; neither word resumes; then 16'h0001 shifts with sof and x = fifteen 0s then 1.
5. MSB_FIRST=0, word 16'h0003.
   -> x = 1,1 followed by fourteen 0s; sof/eof timing identical to scenario 1.
6. WIDTH=1, words 1,0,1 back-to-back.
   -> x = 1,0,1 on three consecutive cycles; sof=eof=1 on each; in_ready never drops below one word of headroom.

Source files
------------

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words over valid/ready and shifts them out one bit per clock with sof/eof markers.
module serial_word_feeder #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sh, sh_n, hold, hold_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hold_full, hold_full_n, accept, last;
    assign in_ready = !hold_full && !rst;
    assign accept   = in_valid && in_ready;
    assign x_valid  = state == SHIFT;
    assign last     = x_valid && cnt == LAST;
    assign x        = x_valid && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
    assign sof      = x_valid && cnt == '0;
    assign eof      = last;
    assign busy     = x_valid || hold_full;
    always_comb begin
        state_n     = state;
        sh_n        = sh;
        hold_n      = hold;
        cnt_n       = cnt;
        hold_full_n = hold_full;
        if (state == IDLE) begin
            if (accept) begin
                state_n = SHIFT;
                sh_n    = in_data;
                cnt_n   = '0;
            end
        end else if (!last) begin
            sh_n  = MSB_FIRST ? sh << 1 : sh >> 1;
            cnt_n = cnt + CW'(1);
            if (accept) begin
                hold_n      = in_data;
                hold_full_n = 1'b1;
            end
        end else begin
            // a held or simultaneously offered word follows with no bubble
            cnt_n = '0;
            if (hold_full) begin
                sh_n        = hold;
                hold_full_n = 1'b0;
            end else if (accept) begin
                sh_n = in_data;
            end else begin
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            hold      <= hold_n;
            cnt       <= cnt_n;
            hold_full <= hold_full_n;
        end
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of three feeder configurations against hand-computed bit streams.
module tb_serial_word_feeder;
    localparam int X = 5, V = 4, S = 3, E = 2, R = 1, B = 0;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] in_data_a = '0, in_data_b = '0;
    logic [0:0]  in_data_c = '0;
    logic in_valid_a = 1'b0, in_valid_b = 1'b0, in_valid_c = 1'b0;
    logic rdy_a, x_a, xv_a, sof_a, eof_a, busy_a;
    logic rdy_b, x_b, xv_b, sof_b, eof_b, busy_b;
    logic rdy_c, x_c, xv_c, sof_c, eof_c, busy_c;
    logic acc_a = 1'b0, acc_b = 1'b0, acc_c = 1'b0;
    logic stall_a = 1'b0;
    logic [15:0] held_a = '0;
    logic [15:0] qa[$], qb[$], qc[$];
    logic [63:0] h [3][6];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(rdy_a),
        .x(x_a), .x_valid(xv_a), .sof(sof_a), .eof(eof_a), .busy(busy_a));
    serial_word_feeder #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(rdy_b),
        .x(x_b), .x_valid(xv_b), .sof(sof_b), .eof(eof_b), .busy(busy_b));
    serial_word_feeder #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(rdy_c),
        .x(x_c), .x_valid(xv_c), .sof(sof_c), .eof(eof_c), .busy(busy_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 6; k++) h[d][k] = '0;
    endtask

    task automatic rec(input int d, input logic [5:0] s);
        for (int k = 0; k < 6; k++) h[d][k] = {h[d][k][62:0], s[k]};
    endtask

    // drive and sample at negedge; an accept flagged here happens at the next posedge
    task automatic cycle(input logic r);
        @(negedge clk);
        rst = r;
        #1;
        rec(0, {x_a, xv_a, sof_a, eof_a, rdy_a, busy_a});
        rec(1, {x_b, xv_b, sof_b, eof_b, rdy_b, busy_b});
        rec(2, {x_c, xv_c, sof_c, eof_c, rdy_c, busy_c});
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        if (acc_c) void'(qc.pop_front());
        in_valid_a = qa.size() > 0;
        in_valid_b = qb.size() > 0;
        in_valid_c = qc.size() > 0;
        if (in_valid_a) in_data_a = qa[0];
        if (in_valid_b) in_data_b = qb[0];
        if (in_valid_c) in_data_c = qc[0][0:0];
        if (stall_a && in_valid_a) check("stable", {48'b0, in_data_a}, {48'b0, held_a});
        stall_a = in_valid_a && !rdy_a;
        held_a  = in_data_a;
        acc_a = in_valid_a && rdy_a;
        acc_b = in_valid_b && rdy_b;
        acc_c = in_valid_c && rdy_c;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0);
    endtask

    initial begin
        clr();
        cycle(1'b1);
        cycle(1'b1);
        check("rst_x", h[0][X][0], 0);
        check("rst_xv", h[0][V][0], 0);
        check("rst_busy", h[0][B][0], 0);
        check("rst_rdy_forced", h[0][R][0], 0);
        cycle(1'b0);
        check("post_rst_rdy", h[0][R][0], 1);
        check("post_rst_sof_eof", {h[0][S][0], h[0][E][0]}, 0);

        clr();
        qa.push_back(16'h9D99);
        run(18);
        check("s1_x", h[0][X][17:0], {1'b0, 16'h9D99, 1'b0});
        check("s1_xv", h[0][V][17:0], {1'b0, 16'hFFFF, 1'b0});
        check("s1_sof", h[0][S][17:0], {1'b0, 16'h8000, 1'b0});
        check("s1_eof", h[0][E][17:0], {1'b0, 16'h0001, 1'b0});
        check("s1_rdy", h[0][R][17:0], 18'h3FFFF);
        check("s1_busy", h[0][B][17:0], {1'b0, 16'hFFFF, 1'b0});

        clr();
        qa.push_back(16'h9D99);
        qa.push_back(16'h0005);
        run(34);
        check("s2_x", h[0][X][33:0], {1'b0, 16'h9D99, 16'h0005, 1'b0});
        check("s2_xv", h[0][V][33:0], {1'b0, 32'hFFFF_FFFF, 1'b0});
        check("s2_sof", h[0][S][33:0], {1'b0, 16'h8000, 16'h8000, 1'b0});
        check("s2_eof", h[0][E][33:0], {1'b0, 16'h0001, 16'h0001, 1'b0});
        check("s2_rdy", h[0][R][33:0], {2'b11, 15'b0, 17'h1FFFF});

        clr();
        qa.push_back(16'hFFFF);
        qa.push_back(16'h0000);
        qa.push_back(16'hAAAA);
        run(50);
        check("s3_x", h[0][X][49:0], {1'b0, 16'hFFFF, 16'h0000, 16'hAAAA, 1'b0});
        check("s3_xv", h[0][V][49:0], {1'b0, 48'hFFFF_FFFF_FFFF, 1'b0});
        check("s3_sof", h[0][S][49:0], {1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b0});
        check("s3_eof", h[0][E][49:0], {1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b0});
        check("s3_rdy", h[0][R][49:0], {2'b11, 15'b0, 1'b1, 15'b0, 17'h1FFFF});

        clr();
        qa.push_back(16'h9D99);
        qa.push_back(16'h1234);
        run(7);
        cycle(1'b1);
        check("s4_rdy_in_rst", h[0][R][0], 0);
        qa.push_back(16'h0001);
        run(18);
        check("s4_after_rst", {h[0][V][17], h[0][B][17], h[0][R][17]}, 3'b001);
        check("s4_x", h[0][X][25:0], {1'b0, 7'b1001110, 1'b0, 16'h0001, 1'b0});
        check("s4_xv", h[0][V][25:0], {1'b0, 7'h7F, 1'b0, 16'hFFFF, 1'b0});
        check("s4_sof", h[0][S][25:0], {1'b0, 7'h40, 1'b0, 16'h8000, 1'b0});
        check("s4_eof", h[0][E][25:0], {1'b0, 7'h00, 1'b0, 16'h0001, 1'b0});
        check("s4_busy", h[0][B][25:0], {1'b0, 7'h7F, 1'b0, 16'hFFFF, 1'b0});
        check("s4_rdy", h[0][R][25:0], {2'b11, 6'b0, 18'h3FFFF});

        clr();
        qb.push_back(16'h0003);
        run(18);
        check("s5_x", h[1][X][17:0], {1'b0, 16'hC000, 1'b0});
        check("s5_sof", h[1][S][17:0], {1'b0, 16'h8000, 1'b0});
        check("s5_eof", h[1][E][17:0], {1'b0, 16'h0001, 1'b0});
        check("s5_xv", h[1][V][17:0], {1'b0, 16'hFFFF, 1'b0});

        clr();
        qc.push_back(16'h1);
        qc.push_back(16'h0);
        qc.push_back(16'h1);
        run(5);
        check("s6_x", h[2][X][4:0], 5'b01010);
        check("s6_sof", h[2][S][4:0], 5'b01110);
        check("s6_eof", h[2][E][4:0], 5'b01110);
        check("s6_xv", h[2][V][4:0], 5'b01110);
        check("s6_rdy", h[2][R][4:0], 5'b11111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
